// File: rtl/cfg_emu_pkg.sv
// Shared types and constants for the configuration shift-register emulator.
// The optional glitch filter is selected with CFG_EMU_GLITCH_FILTER_EN.
package cfg_emu_pkg;

    localparam int DEF_CONFIG_REG_WIDTH = 5164;
    localparam int DEF_SYNC_STAGES      = 2;
    localparam int DEF_CNT_WIDTH        = 16;

    // Classification of a synchronized level change seen in one cycle.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } edge_t;

    // Saturation value of an unsigned counter of the given width.
    function automatic longint unsigned cnt_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/config_reg_emulator_if.sv
// Serial configuration bus between the FPGA config master and the emulated chip.
// The master drives clock, data, load, chip reset and variant select;
// the chip side returns the serial data that falls out of its register.
interface config_reg_emulator_if;

    logic ConfigClk;
    logic ConfigIn;
    logic ConfigLoad;
    logic Reset_not;
    logic SuperpixSel;
    logic ConfigOut;

    modport master (
        output ConfigClk,
        output ConfigIn,
        output ConfigLoad,
        output Reset_not,
        output SuperpixSel,
        input  ConfigOut
    );

    modport slave (
        input  ConfigClk,
        input  ConfigIn,
        input  ConfigLoad,
        input  Reset_not,
        input  SuperpixSel,
        output ConfigOut
    );

endinterface

// File: rtl/cfg_emu_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous input.
// With CFG_EMU_GLITCH_FILTER_EN defined and FILTER set, a transition is only
// reported once the synchronized level has held for two cycles; the level
// output is then taken one flop later so data stays aligned with the edges.
module cfg_emu_sync_edge
    import cfg_emu_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter bit FILTER      = 1'b1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_async,
    output logic  o_level,
    output edge_t o_edge
);

`ifdef CFG_EMU_GLITCH_FILTER_EN
    localparam bit USE_FILTER = FILTER;
`else
    localparam bit USE_FILTER = FILTER & 1'b0;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_sync_level;

    assign w_sync_level = r_sync[SYNC_STAGES-1];

    // Synchronizer chain and one-cycle history of the synchronized level.
    // NOTE: state flops use non-blocking assignments so every stage samples the
    // previous value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= w_sync_level;
        end
    end

    generate
        if (USE_FILTER) begin : g_filter
            logic r_filt;

            // Accepted level: follows the input only after two equal samples.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_filt <= 1'b0;
                end else if (w_sync_level == r_hist) begin
                    r_filt <= r_hist;
                end
            end

            // Report a transition on the cycle the stable level first differs.
            always_comb begin
                o_edge = NONE;
                if ((w_sync_level == r_hist) && (r_hist != r_filt)) begin
                    o_edge = r_hist ? RISE : FALL;
                end
            end

            assign o_level = r_hist;
        end else begin : g_direct
            // Every synchronized change is an edge.
            always_comb begin
                o_edge = NONE;
                if (w_sync_level && !r_hist) begin
                    o_edge = RISE;
                end else if (!w_sync_level && r_hist) begin
                    o_edge = FALL;
                end
            end

            assign o_level = w_sync_level;
        end
    endgenerate

endmodule

// File: rtl/config_reg_emulator.sv
// Chip-side configuration shift register, modelled in FPGA fabric.
// Oversamples the serial config bus, shifts data on ConfigClk rises, latches
// the word to ParallelOut on ConfigLoad rises and loops the MSB back out.
// Optional glitch filter on ConfigClk/ConfigLoad: CFG_EMU_GLITCH_FILTER_EN.
module config_reg_emulator
    import cfg_emu_pkg::*;
#(
    parameter int CONFIG_REG_WIDTH = DEF_CONFIG_REG_WIDTH,
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int CNT_WIDTH        = DEF_CNT_WIDTH
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    config_reg_emulator_if.slave        cfg,
    output logic [CONFIG_REG_WIDTH-1:0] ParallelOut,
    output logic                        superpix_sel_q,
    output logic                        load_pulse,
    output logic [CNT_WIDTH-1:0]        shift_count,
    output logic                        overflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

    logic [CONFIG_REG_WIDTH-1:0] r_shift_reg;
    logic [CONFIG_REG_WIDTH-1:0] r_parallel;
    logic                        r_config_out;
    logic                        r_sel_q;
    logic                        r_load_pulse;
    logic [CNT_WIDTH-1:0]        r_shift_count;
    logic                        r_overflow;
    logic                        r_rstn_q;

    logic                        w_in_level;
    logic                        w_sel_level;
    logic                        w_rstn_level;
    logic                        w_clk_level_unused;
    logic                        w_load_level_unused;
    edge_t                       w_clk_edge;
    edge_t                       w_load_edge;
    edge_t                       w_in_edge_unused;
    edge_t                       w_sel_edge_unused;
    edge_t                       w_rstn_edge_unused;
    logic                        w_edges_en;
    logic                        w_clk_rise;
    logic                        w_load_rise;
    logic [CNT_WIDTH-1:0]        w_cnt_base;
    logic [CNT_WIDTH-1:0]        w_cnt_next;
    logic                        w_ovf_base;
    logic                        w_ovf_next;

    cfg_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .FILTER(1'b1)) u_sync_clk (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .i_async(cfg.ConfigClk),
        .o_level(w_clk_level_unused), .o_edge(w_clk_edge));

    cfg_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .FILTER(1'b1)) u_sync_load (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .i_async(cfg.ConfigLoad),
        .o_level(w_load_level_unused), .o_edge(w_load_edge));

    cfg_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .FILTER(1'b1)) u_sync_in (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .i_async(cfg.ConfigIn),
        .o_level(w_in_level), .o_edge(w_in_edge_unused));

    cfg_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .FILTER(1'b1)) u_sync_sel (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .i_async(cfg.SuperpixSel),
        .o_level(w_sel_level), .o_edge(w_sel_edge_unused));

    cfg_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .FILTER(1'b0)) u_sync_rstn (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .i_async(cfg.Reset_not),
        .o_level(w_rstn_level), .o_edge(w_rstn_edge_unused));

    // Edges count only once chip reset has been seen released for a full cycle,
    // so a ConfigClk already high at release never turns into a shift.
    assign w_edges_en  = w_rstn_level && r_rstn_q;
    assign w_clk_rise  = w_edges_en && (w_clk_edge == RISE);
    assign w_load_rise = w_edges_en && (w_load_edge == RISE);

    // Next shift count and overflow; a coincident load zeroes them before the shift counts.
    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_cnt_base = w_load_rise ? '0 : r_shift_count;
        w_ovf_base = w_load_rise ? 1'b0 : r_overflow;
        w_cnt_next = w_cnt_base;
        w_ovf_next = w_ovf_base;
        if (w_clk_rise) begin
            if (w_cnt_base != CNT_MAX) begin
                w_cnt_next = w_cnt_base + 1'b1;
            end
            if (int'(w_cnt_next) > CONFIG_REG_WIDTH) begin
                w_ovf_next = 1'b1;
            end
        end
    end

    // Delayed synchronized chip reset, used to qualify edges after release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rstn_q <= 1'b0;
        end else begin
            r_rstn_q <= w_rstn_level;
        end
    end

    // Shift register, parallel latch, loopback bit and bookkeeping counters.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_shift_reg   <= '0;
            r_parallel    <= '0;
            r_config_out  <= 1'b0;
            r_sel_q       <= 1'b0;
            r_load_pulse  <= 1'b0;
            r_shift_count <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_load_pulse <= 1'b0;
            if (!w_rstn_level) begin
                r_shift_reg   <= '0;
                r_parallel    <= '0;
                r_config_out  <= 1'b0;
                r_shift_count <= '0;
                r_overflow    <= 1'b0;
            end else begin
                if (w_load_rise) begin
                    r_parallel   <= r_shift_reg;
                    r_sel_q      <= w_sel_level;
                    r_load_pulse <= 1'b1;
                end
                if (w_clk_rise) begin
                    r_shift_reg  <= {r_shift_reg[CONFIG_REG_WIDTH-2:0], w_in_level};
                    r_config_out <= r_shift_reg[CONFIG_REG_WIDTH-2];
                end
                r_shift_count <= w_cnt_next;
                r_overflow    <= w_ovf_next;
            end
        end
    end

    assign cfg.ConfigOut   = r_config_out;
    assign ParallelOut     = r_parallel;
    assign superpix_sel_q  = r_sel_q;
    assign load_pulse      = r_load_pulse;
    assign shift_count     = r_shift_count;
    assign overflow        = r_overflow;

endmodule

// File: tb/tb_config_reg_emulator.sv
// Directed bench for config_reg_emulator with a 16-bit register and
// ConfigClk running at ACLK/8. Expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_config_reg_emulator;

    localparam int W   = 16;
    localparam int SS  = 2;
    localparam int CW  = 16;
`ifdef CFG_EMU_GLITCH_FILTER_EN
    localparam int LAT = SS + 2;
`else
    localparam int LAT = SS + 1;
`endif

    logic          aclk;
    logic          aresetn;
    logic [W-1:0]  parallel_out;
    logic          sel_q;
    logic          load_pulse;
    logic [CW-1:0] shift_count;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    config_reg_emulator_if cfg_if ();

    config_reg_emulator #(
        .CONFIG_REG_WIDTH(W),
        .SYNC_STAGES(SS),
        .CNT_WIDTH(CW)
    ) dut (
        .S_AXI_ACLK(aclk),
        .S_AXI_ARESETN(aresetn),
        .cfg(cfg_if.slave),
        .ParallelOut(parallel_out),
        .superpix_sel_q(sel_q),
        .load_pulse(load_pulse),
        .shift_count(shift_count),
        .overflow(overflow)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One serial bit: data settles, ConfigClk high for 4 ACLK, low for 4 ACLK.
    task automatic shift_bit(input logic b);
        @(negedge aclk);
        cfg_if.ConfigIn = b;
        repeat (4) @(negedge aclk);
        cfg_if.ConfigClk = 1'b1;
        repeat (4) @(negedge aclk);
        cfg_if.ConfigClk = 1'b0;
    endtask

    task automatic shift_word(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            shift_bit(val[i]);
        end
    endtask

    // Raise ConfigLoad (optionally with ConfigClk), measure pulse latency and
    // confirm that holding the strobe high gives no second pulse.
    task automatic do_load(input logic with_clk, input logic keep_high);
        int lat;
        int extra;
        lat   = 0;
        extra = 0;
        @(negedge aclk);
        cfg_if.ConfigLoad = 1'b1;
        if (with_clk) cfg_if.ConfigClk = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge aclk);
            if (load_pulse) begin
                lat = i;
                break;
            end
        end
        check("load_latency", lat, LAT);
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            if (load_pulse) extra++;
        end
        check("load_single_pulse", extra, 0);
        if (with_clk) cfg_if.ConfigClk = 1'b0;
        if (!keep_high) cfg_if.ConfigLoad = 1'b0;
        repeat (4) @(negedge aclk);
    endtask

    initial begin
        logic [15:0] word;
        logic [19:0] long_word;
        int          lat;

        aresetn            = 1'b0;
        cfg_if.ConfigClk   = 1'b0;
        cfg_if.ConfigIn    = 1'b0;
        cfg_if.ConfigLoad  = 1'b0;
        cfg_if.Reset_not   = 1'b1;
        cfg_if.SuperpixSel = 1'b0;
        repeat (4) @(negedge aclk);

        check("rst_parallel", parallel_out, 0);
        check("rst_count", shift_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_pulse", load_pulse, 0);
        check("rst_cfgout", cfg_if.ConfigOut, 0);
        check("rst_sel", sel_q, 0);

        aresetn = 1'b1;
        repeat (6) @(negedge aclk);

        // Loopback: after the word is in, ConfigOut walks through it MSB first.
        word = 16'hA5C3;
        shift_word({16'h0, word}, 16);
        check("loop_out_0", cfg_if.ConfigOut, word[15]);
        for (int k = 1; k < 16; k++) begin
            shift_bit(1'b0);
            check($sformatf("loop_out_%0d", k), cfg_if.ConfigOut, word[15-k]);
        end
        shift_bit(1'b0);
        check("loop_parallel", parallel_out, 0);
        check("loop_count", shift_count, 32);
        check("loop_overflow", overflow, 1);

        // Plain load of a full word.
        cfg_if.SuperpixSel = 1'b1;
        shift_word(32'h0000A5C3, 16);
        check("preload_count", shift_count, 48);
        do_load(1'b0, 1'b0);
        check("load_parallel", parallel_out, 16'hA5C3);
        check("load_count", shift_count, 0);
        check("load_overflow", overflow, 0);
        check("load_sel", sel_q, 1);

        // 20 bits: overflow appears on the 17th shift, not the 16th.
        cfg_if.SuperpixSel = 1'b0;
        long_word = 20'hB1234;
        for (int i = 19; i >= 0; i--) begin
            shift_bit(long_word[i]);
            if (i == 4) begin
                check("ovf_count16", shift_count, 16);
                check("ovf_at16", overflow, 0);
            end
            if (i == 3) check("ovf_at17", overflow, 1);
        end
        check("ovf_count20", shift_count, 20);
        check("ovf_flag20", overflow, 1);
        do_load(1'b0, 1'b0);
        check("ovf_parallel", parallel_out, 16'h1234);
        check("ovf_count_clr", shift_count, 0);
        check("ovf_flag_clr", overflow, 0);
        check("ovf_sel", sel_q, 0);

        // Chip reset mid-word with a ConfigClk rise inside the low window.
        shift_word(32'h000000FF, 8);
        check("chip_pre_count", shift_count, 8);
        @(negedge aclk);
        cfg_if.Reset_not = 1'b0;
        @(negedge aclk);
        cfg_if.ConfigClk = 1'b1;
        repeat (3) @(negedge aclk);
        cfg_if.Reset_not = 1'b1;
        repeat (6) @(negedge aclk);
        check("chip_shift_reg", dut.r_shift_reg, 0);
        check("chip_parallel", parallel_out, 0);
        check("chip_count", shift_count, 0);
        check("chip_overflow", overflow, 0);
        check("chip_cfgout", cfg_if.ConfigOut, 0);
        cfg_if.ConfigClk = 1'b0;
        repeat (4) @(negedge aclk);
        check("chip_fall_count", shift_count, 0);

        // Shift latency from the ConfigClk pin rise to shift_count update.
        cfg_if.ConfigIn = 1'b1;
        repeat (4) @(negedge aclk);
        cfg_if.ConfigClk = 1'b1;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge aclk);
            if (shift_count != 0) begin
                lat = i;
                break;
            end
        end
        check("shift_latency", lat, LAT);
        repeat (4) @(negedge aclk);
        cfg_if.ConfigClk = 1'b0;
        repeat (4) @(negedge aclk);
        check("lat_shift_reg", dut.r_shift_reg, 16'h0001);

        // Coincident clock and load rises.
        shift_word(32'h000000FF, 16);
        check("coin_pre_overflow", overflow, 1);
        cfg_if.ConfigIn = 1'b1;
        repeat (4) @(negedge aclk);
        do_load(1'b1, 1'b1);
        check("coin_parallel", parallel_out, 16'h00FF);
        check("coin_shift_reg", dut.r_shift_reg, 16'h01FF);
        check("coin_count", shift_count, 1);
        check("coin_overflow", overflow, 0);

        // Shift while ConfigLoad stays high: honoured, no new load.
        shift_bit(1'b0);
        check("held_shift_reg", dut.r_shift_reg, 16'h03FE);
        check("held_count", shift_count, 2);
        check("held_parallel", parallel_out, 16'h00FF);
        cfg_if.ConfigLoad = 1'b0;
        repeat (6) @(negedge aclk);

`ifdef CFG_EMU_GLITCH_FILTER_EN
        // Single-cycle pulses on ConfigClk and ConfigLoad are rejected.
        @(negedge aclk);
        cfg_if.ConfigClk = 1'b1;
        @(negedge aclk);
        cfg_if.ConfigClk = 1'b0;
        repeat (8) @(negedge aclk);
        check("glitch_clk_count", shift_count, 2);
        @(negedge aclk);
        cfg_if.ConfigLoad = 1'b1;
        @(negedge aclk);
        cfg_if.ConfigLoad = 1'b0;
        repeat (8) @(negedge aclk);
        check("glitch_load_count", shift_count, 2);
        check("glitch_load_parallel", parallel_out, 16'h00FF);
`endif

        // Fabric reset asserted between clock edges clears state at once.
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        check("async_parallel", parallel_out, 0);
        check("async_shift_reg", dut.r_shift_reg, 0);
        check("async_count", shift_count, 0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/config_reg_emulator.md
Name: config_reg_emulator

Overview:
FPGA-fabric model of the chip-side configuration shift register, i.e. the responder to the FPGA config-register master. It oversamples ConfigClk, ConfigIn, ConfigLoad, Reset_not and SuperpixSel on the fabric clock. It shifts serial data into a CONFIG_REG_WIDTH register, latches it to a parallel output on ConfigLoad, and drives ConfigOut back. It is used for loopback bring-up and for a self-contained simulation of the config path without silicon.

Parameters:
- CONFIG_REG_WIDTH, 5164, length of the emulated shift register in bits (minimum 2).
- SYNC_STAGES, 2, synchronizer flops per asynchronous input (minimum 2).
- CNT_WIDTH, 16, width of shift_count.

Ports:
- S_AXI_ACLK  in  1  fabric clock; ConfigClk must be at most S_AXI_ACLK/4.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- ConfigClk  in  1  serial clock from the master, asynchronous.
- ConfigIn  in  1  serial data from the master.
- ConfigLoad  in  1  parallel-load strobe from the master.
- Reset_not  in  1  chip-level active-low reset from the master.
- SuperpixSel  in  1  superpixel variant select from the master.
- ConfigOut  out  1  serial data back to the master.
- ParallelOut  out  CONFIG_REG_WIDTH  latched configuration word.
- superpix_sel_q  out  1  SuperpixSel captured at the last load.
- load_pulse  out  1  one-cycle pulse when ParallelOut updates.
- shift_count  out  CNT_WIDTH  ConfigClk rising edges since the last load or reset.
- overflow  out  1  more than CONFIG_REG_WIDTH shifts occurred since the last load.

Behaviour:
- Clock and reset: one clock (S_AXI_ACLK); reset S_AXI_ARESETN is asynchronous, active-low.
- Reset values while S_AXI_ARESETN is low:
  - shift_reg, ParallelOut, ConfigOut, superpix_sel_q, load_pulse, shift_count, overflow = 0.
  - Synchronizer and edge-history flops = 0.
- Input sampling:
  - Each input passes through SYNC_STAGES flops.
  - Edge detection compares the last synchronized value with one further history flop.
- Chip reset (synced Reset_not = 0): shift_reg, ParallelOut, ConfigOut, shift_count and overflow clear on the next cycle; all edges are ignored.
- Edges are accepted only from the second cycle after synced Reset_not is seen high. A ConfigClk already high at release does not produce a shift.
- Shift, on a ConfigClk rising edge:
  - shift_reg <= {shift_reg[W-2:0], ConfigIn_sync}; ConfigIn is sampled from the same synchronizer depth.
  - ConfigOut <= shift_reg[W-2], so ConfigOut always equals the register MSB one cycle after the edge.
  - shift_count increments, saturating at 2^CNT_WIDTH-1.
  - overflow sets once shift_count exceeds CONFIG_REG_WIDTH and is sticky until load or reset.
- ConfigClk falling edges cause no action.
- Load, on a ConfigLoad rising edge:
  - ParallelOut <= shift_reg and superpix_sel_q <= SuperpixSel_sync.
  - load_pulse = 1 for exactly one cycle; shift_count and overflow clear.
  - Load latency is SYNC_STAGES+1 cycles from the pin edge to ParallelOut valid.
- Simultaneous ConfigClk and ConfigLoad rising edges in the same cycle:
  - Load captures the pre-shift shift_reg, then the shift is applied.
  - shift_count ends at 1.
- A held ConfigLoad high produces only one load. Shifts during ConfigLoad high are honoured.
- An S_AXI_ARESETN assertion mid-shift discards all state immediately.

Optional Feature:
CFG_EMU_GLITCH_FILTER_EN
- Defined: a ConfigClk or ConfigLoad transition is accepted only if the synchronized level has been stable for 2 consecutive cycles. This adds 1 cycle of latency to shift and load. Single-cycle pulses are rejected and shift_count does not change.
- Undefined: every synchronized transition is an edge; latencies are as stated above.

Decomposition:
- Package cfg_emu_pkg:
  - Default CONFIG_REG_WIDTH and SYNC_STAGES constants.
  - A CNT_MAX constant function.
  - An edge-type enum (NONE, RISE, FALL).
- Sub-module cfg_emu_sync_edge: parameterized synchronizer plus edge detector, with the optional glitch filter inside. Instantiated for ConfigClk, ConfigLoad and Reset_not; ConfigIn and SuperpixSel use its level output only.

Test Plan (CONFIG_REG_WIDTH=16, ConfigClk = ACLK/8):
- Shift 0xA5C3, MSB first, then pulse ConfigLoad -> ParallelOut=16'hA5C3, load_pulse high 1 cycle, shift_count=0, overflow=0.
- Shift 0xA5C3, then 16 more zero bits -> ConfigOut reproduces 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on successive edges; ParallelOut unchanged at its reset value 0.
- Shift 20 bits then load -> shift_count reaches 20, overflow=1 before the load, both clear after it; ParallelOut = last 16 bits shifted.
- Drive Reset_not low for 4 ACLK cycles mid-word -> shift_reg and ParallelOut read 0; ConfigClk edges during low produce no shift_count change.
- Coincident ConfigClk and ConfigLoad rise after loading 0x00FF with next bit 1 -> ParallelOut=16'h00FF, shift_reg=16'h01FF, shift_count=1.
- With CFG_EMU_GLITCH_FILTER_EN: 1-ACLK ConfigClk glitch -> shift_count stays 0; normal edges still shift with one extra cycle of latency.
